uart_rx_core: RTL



---
 rtl/uart_rx_core.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver (LSB first, idle high) with a
// valid/ready byte output, frame-error and overrun pulses.
// Baud timing comes from an internal divider of the system clock.
module uart_rx_core #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = ($clog2(BAUD_DIV) > 13) ? $clog2(BAUD_DIV) : 13;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             sync1_r;
  logic             sync2_r;
  logic             hist_r;
  logic             rx_sync_s;
  logic             fall_s;
  logic [CNT_W-1:0] cnt_r;
  logic             cnt_clr_s;
  logic [2:0]       bit_idx_r;
  logic [2:0]       bit_idx_nxt_s;
  logic [7:0]       shift_r;
  logic [7:0]       shift_nxt_s;
  logic             deliver_s;
  logic             ferr_s;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic             frame_err_r;
  logic             overrun_r;
  logic             busy_r;

  assign rx_sync_s = sync2_r;
  assign fall_s    = hist_r & ~sync2_r;

  // Two-flop synchronizer on the raw line plus a history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      hist_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  // Baud counter: restarts on every state entry and at every bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Next-state, bit sampling and stop-bit decision.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_clr_s     = 1'b0;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    deliver_s     = 1'b0;
    ferr_s        = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_clr_s = 1'b1;
        if (fall_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_clr_s = 1'b1;
          if (!rx_sync_s) begin
            state_nxt_s   = DATA;
            bit_idx_nxt_s = 3'd0;
          end else begin
            state_nxt_s = IDLE;  // glitch shorter than half a bit
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_clr_s   = 1'b1;
          shift_nxt_s = {rx_sync_s, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_nxt_s   = STOP;
            bit_idx_nxt_s = 3'd0;
          end else begin
            state_nxt_s   = DATA;
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          // Return to IDLE mid stop bit so an adjacent start bit is caught.
          cnt_clr_s   = 1'b1;
          state_nxt_s = IDLE;
          if (rx_sync_s) begin
            deliver_s = 1'b1;
          end else begin
            ferr_s = 1'b1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_clr_s   = 1'b1;
      end
    endcase
  end

  // FSM state, bit index, shift register and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
    end
  end

  // Holding register with valid/ready handshake and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= ferr_s;
      overrun_r   <= 1'b0;
      if (deliver_s) begin
        if (!rx_valid_r || rx_ready) begin
          rx_data_r  <= shift_r;
          rx_valid_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;  // old byte kept, new one dropped
        end
      end else if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule
